decoder2x4_hold: RTL and testbench



---
 rtl/decoder2x4_hold_if.sv | 24 ++
 rtl/decoder2x4_hold.sv | 67 ++++++
 tb/tb_decoder2x4_hold.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/decoder2x4_hold_if.sv
// Handshake and output bundle for decoder2x4_hold: index request in, held one-hot strobe out.
interface decoder2x4_hold_if #(
  parameter int IN_W = 2
);
  localparam int OUT_W = 1 << IN_W;

  logic             en;
  logic             in_valid;
  logic [IN_W-1:0]  in;
  logic             in_ready;
  logic [OUT_W-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output en, in_valid, in,
    input  in_ready, out, busy, done
  );

  modport slave (
    input  en, in_valid, in,
    output in_ready, out, busy, done
  );
endinterface

// File: rtl/decoder2x4_hold.sv
// Registered, handshaked binary-to-one-hot decoder; each accepted index is held for HOLD_CYCLES
// cycles, with back-to-back reload on the last hold cycle and a done pulse on normal completion.
module decoder2x4_hold #(
  parameter int IN_W        = 2,
  parameter int HOLD_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  decoder2x4_hold_if.slave bus
);
  localparam int OUT_W = 1 << IN_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRIVE = 1'b1;

  localparam logic [7:0] CNT_LAST = 8'(HOLD_CYCLES - 1);

  logic [0:0]       state;
  logic [7:0]       cnt;
  logic             last_cycle;
  logic             accept;
  logic [OUT_W-1:0] onehot;

  // The final hold cycle doubles as an accept slot so consecutive indices leave no gap on out.
  assign last_cycle   = (state == DRIVE) && (cnt == CNT_LAST);
  assign bus.in_ready = bus.en && ((state == IDLE) || last_cycle);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    onehot         = '0;
    onehot[bus.in] = 1'b1;
  end

  // Enable low aborts any hold without a done pulse; done is otherwise a one-edge strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.out  <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (!bus.en) begin
        state    <= IDLE;
        cnt      <= '0;
        bus.out  <= '0;
        bus.busy <= 1'b0;
      end else if (accept) begin
        state    <= DRIVE;
        cnt      <= '0;
        bus.out  <= onehot;
        bus.busy <= 1'b1;
      end else if (state == DRIVE) begin
        if (last_cycle) begin
          state    <= IDLE;
          cnt      <= '0;
          bus.out  <= '0;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_decoder2x4_hold.sv
// Bench for decoder2x4_hold: timeline model of the 4-cycle instance checked every cycle,
// directed literal checks, plus a HOLD_CYCLES=1 instance checked against literals.
module tb_decoder2x4_hold;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_idx = 2'd0;

  int total_checks = 0;
  int passed_checks = 0;

  decoder2x4_hold_if #(.IN_W(2)) bus ();
  decoder2x4_hold_if #(.IN_W(2)) bus1 ();

  assign bus.en        = en;
  assign bus.in_valid  = in_valid;
  assign bus.in        = in_idx;
  assign bus1.en       = en;
  assign bus1.in_valid = in_valid;
  assign bus1.in       = in_idx;

  decoder2x4_hold #(.IN_W(2), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  decoder2x4_hold #(.IN_W(2), .HOLD_CYCLES(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  always #5 clk = ~clk;

  // Model: an accepted index owns the output timeline for HOLD cycles; done lands one cycle later.
  int         cyc = 0;
  int         hold_end = -1;
  int         done_at = -1;
  logic [3:0] cur_val = 4'd0;

  always @(posedge clk) begin
    bit rdy;
    rdy = en && (cyc >= hold_end);
    cyc++;
    if (rst || !en) begin
      cur_val  = 4'd0;
      hold_end = -1;
      done_at  = -1;
    end else if (in_valid && rdy) begin
      cur_val  = 4'd1 << in_idx;
      hold_end = cyc + HOLD - 1;
      done_at  = cyc + HOLD;
    end
  end

  function automatic logic [3:0] exp_out();
    return (cyc <= hold_end) ? cur_val : 4'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp)
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    else
      passed_checks++;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic v, input logic [1:0] i);
    @(negedge clk);
    rst      = r;
    en       = e;
    in_valid = v;
    in_idx   = i;
  endtask

  task automatic tick(input logic r, input logic e, input logic v, input logic [1:0] i);
    applyStimulus(r, e, v, i);
    @(posedge clk);
    #2;
  endtask

  // Registered outputs are compared just after each edge, in_ready just after inputs settle.
  initial begin
    @(posedge clk);
    forever begin
      #1;
      checkOutput("model_out", 32'(bus.out), 32'(exp_out()));
      checkOutput("model_busy", 32'(bus.busy), 32'(exp_out() != 4'd0));
      checkOutput("model_done", 32'(bus.done), 32'(cyc == done_at));
      @(negedge clk);
      #1;
      checkOutput("model_ready", 32'(bus.in_ready), 32'(en && (cyc >= hold_end)));
      @(posedge clk);
    end
  end

  initial begin
    logic [3:0] sweep_exp [4];
    sweep_exp[0] = 4'b0001;
    sweep_exp[1] = 4'b0010;
    sweep_exp[2] = 4'b0100;
    sweep_exp[3] = 4'b1000;

    // Reset and idle
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick(0, 1, 0, 0);
    checkOutput("idle_out", 32'(bus.out), 32'h0);
    checkOutput("idle_ready", 32'(bus.in_ready), 32'h1);

    // Single decode of index 2
    tick(0, 1, 1, 2);
    checkOutput("single_out_t1", 32'(bus.out), 32'h4);
    checkOutput("single_ready_t1", 32'(bus.in_ready), 32'h0);
    for (int k = 0; k < 3; k++) tick(0, 1, 0, 0);
    checkOutput("single_out_t4", 32'(bus.out), 32'h4);
    checkOutput("single_ready_t4", 32'(bus.in_ready), 32'h1);
    tick(0, 1, 0, 0);
    checkOutput("single_out_t5", 32'(bus.out), 32'h0);
    checkOutput("single_done_t5", 32'(bus.done), 32'h1);
    tick(0, 1, 0, 0);
    checkOutput("single_done_t6", 32'(bus.done), 32'h0);

    // Back-to-back: 01 then 11 with no zero gap
    tick(0, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 1, 3);
      checkOutput("b2b_first", 32'(bus.out), 32'h2);
    end
    tick(0, 1, 1, 3);
    checkOutput("b2b_switch_out", 32'(bus.out), 32'h8);
    checkOutput("b2b_switch_done", 32'(bus.done), 32'h0);
    for (int k = 0; k < 3; k++) tick(0, 1, 0, 0);
    checkOutput("b2b_second_end", 32'(bus.out), 32'h8);
    tick(0, 1, 0, 0);
    checkOutput("b2b_done", 32'(bus.done), 32'h1);

    // Abort on the second hold cycle
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 2);
    #1;
    checkOutput("abort_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #2;
    checkOutput("abort_out", 32'(bus.out), 32'h0);
    checkOutput("abort_busy", 32'(bus.busy), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1, 1);
      checkOutput("abort_no_done", 32'(bus.done), 32'h0);
    end

    // Ignored request while holding 0001
    tick(0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 1, 3);
      checkOutput("ignore_hold", 32'(bus.out), 32'h1);
    end
    tick(0, 1, 0, 0);
    checkOutput("ignore_end_out", 32'(bus.out), 32'h0);
    checkOutput("ignore_end_done", 32'(bus.done), 32'h1);

    // Sweep 0..3, reset during the last hold
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 1, 2'(i));
      checkOutput("sweep_out", 32'(bus.out), 32'(sweep_exp[i]));
      tick(0, 1, 0, 0);
      tick(0, 1, 0, 0);
      if (i < 3) begin
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        checkOutput("sweep_done", 32'(bus.done), 32'h1);
      end
    end
    tick(1, 1, 0, 0);
    checkOutput("sweep_rst_out", 32'(bus.out), 32'h0);
    checkOutput("sweep_rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("sweep_rst_done", 32'(bus.done), 32'h0);

    // One-cycle hold instance: continuous stream then completion
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 1, 2'(i));
      checkOutput("h1_out", 32'(bus1.out), 32'(sweep_exp[i]));
      checkOutput("h1_done", 32'(bus1.done), 32'h0);
      checkOutput("h1_ready", 32'(bus1.in_ready), 32'h1);
    end
    tick(0, 1, 0, 0);
    checkOutput("h1_end_out", 32'(bus1.out), 32'h0);
    checkOutput("h1_end_done", 32'(bus1.done), 32'h1);
    tick(0, 1, 0, 0);
    checkOutput("h1_idle_done", 32'(bus1.done), 32'h0);
    for (int k = 0; k < 4; k++) tick(0, 1, 0, 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end
endmodule
